// File: rtl/vc_pop_arbiter.sv
// vc_pop_arbiter: pops at most one VC FIFO head per cycle toward the D0/D1 demux.
// VC0 has strict priority; a starvation counter forces a VC1 grant after
// STARVE_LIMIT consecutive VC0 grants while VC1 was eligible.
module vc_pop_arbiter #(
    parameter int unsigned DATA_W       = 6,
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              init,
    input  logic              vc0_empty,
    input  logic              vc1_empty,
    input  logic [DATA_W-1:0] vc0_data,
    input  logic [DATA_W-1:0] vc1_data,
    input  logic              d0_almost_full,
    input  logic              d1_almost_full,
    output logic              vc0_pop,
    output logic              vc1_pop,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic [1:0]        state,
    output logic              idle
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned VC_BIT = 4;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_INIT   = 2'd1,
        ST_IDLE   = 2'd2,
        ST_ACTIVE = 2'd3
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [CNT_W-1:0]  starve_q;
    logic [CNT_W-1:0]  starve_d;
    logic [DATA_W-1:0] data_d;
    logic              valid_d;
    logic              run_c;
    logic              vc0_blocked_c;
    logic              vc1_blocked_c;
    logic              vc0_elig;
    logic              vc1_elig;

    // Next state, eligibility, grant and next register values
    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        data_d   = '0;
        valid_d  = 1'b0;
        vc0_pop  = 1'b0;
        vc1_pop  = 1'b0;

        // Pops only allowed while running, out of init and out of reset
        run_c = reset_L && !init && (state_q == ST_IDLE || state_q == ST_ACTIVE);

        vc0_blocked_c = vc0_data[VC_BIT] ? d1_almost_full : d0_almost_full;
        vc1_blocked_c = vc1_data[VC_BIT] ? d1_almost_full : d0_almost_full;
        vc0_elig      = run_c && !vc0_empty && !vc0_blocked_c;
        vc1_elig      = run_c && !vc1_empty && !vc1_blocked_c;

        if (vc1_elig && (starve_q == LIMIT || !vc0_elig)) begin
            vc1_pop = 1'b1;
        end else if (vc0_elig) begin
            vc0_pop = 1'b1;
        end

        if (vc1_pop) begin
            data_d  = vc1_data;
            valid_d = 1'b1;
        end else if (vc0_pop) begin
            data_d  = vc0_data;
            valid_d = 1'b1;
        end

        // Count VC0 wins only while VC1 is actually waiting
        if (vc1_pop || !vc1_elig) begin
            starve_d = '0;
        end else if (vc0_pop) begin
            starve_d = (starve_q < LIMIT) ? starve_q + CNT_W'(1) : LIMIT;
        end

        case (state_q)
            ST_RESET:  state_d = ST_INIT;
            ST_INIT:   state_d = ST_IDLE;
            ST_IDLE:   if (!vc0_empty || !vc1_empty) state_d = ST_ACTIVE;
            ST_ACTIVE: if (vc0_empty && vc1_empty) state_d = ST_IDLE;
            default:   state_d = ST_RESET;
        endcase
        if (init) begin
            state_d = ST_INIT;
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= ST_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // Output word, valid, idle flag and starvation counter
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            data_out  <= '0;
            valid_out <= 1'b0;
            idle      <= 1'b0;
            starve_q  <= '0;
        end else begin
            data_out  <= data_d;
            valid_out <= valid_d;
            idle      <= (state_d == ST_IDLE);
            starve_q  <= starve_d;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_vc_pop_arbiter.sv
// Bench for vc_pop_arbiter: directed scenarios with literal expectations plus
// a randomized run, all checked every cycle against a behavioural model.
module tb_vc_pop_arbiter;

    localparam int LIMIT = 3;

    logic       clk = 1'b0;
    logic       reset_L = 1'b1;
    logic       init = 1'b1;
    logic       vc0_empty = 1'b1;
    logic       vc1_empty = 1'b1;
    logic [5:0] vc0_data = '0;
    logic [5:0] vc1_data = '0;
    logic       d0_almost_full = 1'b0;
    logic       d1_almost_full = 1'b0;
    logic       vc0_pop;
    logic       vc1_pop;
    logic [5:0] data_out;
    logic       valid_out;
    logic [1:0] state;
    logic       idle;

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    // Model: state code 0..3, starvation count, and the registered word
    int       m_state = 0;
    int       m_cnt   = 0;
    bit       m_valid = 1'b0;
    bit [5:0] m_data  = '0;

    vc_pop_arbiter #(.DATA_W(6), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset_L(reset_L), .init(init),
        .vc0_empty(vc0_empty), .vc1_empty(vc1_empty),
        .vc0_data(vc0_data), .vc1_data(vc1_data),
        .d0_almost_full(d0_almost_full), .d1_almost_full(d1_almost_full),
        .vc0_pop(vc0_pop), .vc1_pop(vc1_pop),
        .data_out(data_out), .valid_out(valid_out),
        .state(state), .idle(idle)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit elig(input bit emp, input logic [5:0] d);
        bit af;
        af = d[4] ? d1_almost_full : d0_almost_full;
        return reset_L && !init && (m_state >= 2) && !emp && !af;
    endfunction

    function automatic bit grant1();
        return elig(vc1_empty, vc1_data) && (m_cnt == LIMIT || !elig(vc0_empty, vc0_data));
    endfunction

    function automatic bit grant0();
        return elig(vc0_empty, vc0_data) && !grant1();
    endfunction

    // Model update on each edge
    always @(posedge clk or negedge reset_L) begin
        bit g0, g1, e1;
        if (!reset_L) begin
            m_state = 0; m_cnt = 0; m_valid = 0; m_data = '0;
        end else begin
            g0 = grant0();
            g1 = grant1();
            e1 = elig(vc1_empty, vc1_data);
            m_valid = g0 || g1;
            m_data  = g1 ? vc1_data : (g0 ? vc0_data : 6'd0);
            if (g1 || !e1) m_cnt = 0;
            else if (g0)   m_cnt = (m_cnt + 1 > LIMIT) ? LIMIT : m_cnt + 1;
            if (init)                               m_state = 1;
            else if (m_state == 0)                  m_state = 1;
            else if (m_state == 1)                  m_state = 2;
            else if (m_state == 2 && (!vc0_empty || !vc1_empty)) m_state = 3;
            else if (m_state == 3 && vc0_empty && vc1_empty)     m_state = 2;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_on) begin
            check("m_vc0_pop",   8'(vc0_pop),   8'(grant0()));
            check("m_vc1_pop",   8'(vc1_pop),   8'(grant1()));
            check("m_valid_out", 8'(valid_out), 8'(m_valid));
            check("m_data_out",  8'(data_out),  8'(m_data));
            check("m_state",     8'(state),     8'(m_state));
            check("m_idle",      8'(idle),      8'(m_state == 2));
            if (vc0_pop && vc1_pop) check("both_pops", 8'd1, 8'd0);
        end
    end

    task automatic starve_pattern(input string nm);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check(nm, 8'(vc1_pop), 8'(i % 4 == 3));
            tick();
        end
    endtask

    initial begin
        #3 reset_L = 1'b0;
        #1 chk_on = 1'b1;
        tick(); tick();
        @(negedge clk);
        check("rst_state", 8'(state), 8'd0);
        tick();

        // Leave reset into INIT, then drop init into IDLE
        reset_L = 1'b1;
        tick();
        check("init_state", 8'(state), 8'd1);
        init = 1'b0;
        tick();
        check("idle_state", 8'(state), 8'd2);
        check("idle_flag",  8'(idle),  8'd1);

        // VC0 only: heads 0x05 then 0x15
        vc0_empty = 1'b0; vc0_data = 6'h05;
        @(negedge clk);
        check("vc0_pop_1", 8'(vc0_pop), 8'd1);
        tick();
        vc0_data = 6'h15;
        @(negedge clk);
        check("vc0_pop_2", 8'(vc0_pop), 8'd1);
        check("dout_05",   8'(data_out), 8'h05);
        check("act_state", 8'(state),    8'd3);
        tick();
        vc0_empty = 1'b1;
        @(negedge clk);
        check("dout_15",  8'(data_out),  8'h15);
        check("valid_15", 8'(valid_out), 8'd1);
        check("no_pop",   8'(vc0_pop),   8'd0);
        tick();
        check("back_idle", 8'(state),     8'd2);
        check("valid_off", 8'(valid_out), 8'd0);

        // Starvation guard: VC0,VC0,VC0,VC1 repeating
        vc0_empty = 1'b0; vc0_data = 6'h01;
        vc1_empty = 1'b0; vc1_data = 6'h11;
        starve_pattern("starve");

        // Back-pressure on D0 only
        d0_almost_full = 1'b1; vc0_data = 6'h02; vc1_data = 6'h12;
        @(negedge clk);
        check("bp_vc0_pop", 8'(vc0_pop), 8'd0);
        check("bp_vc1_pop", 8'(vc1_pop), 8'd1);
        tick();
        check("bp_dout_12", 8'(data_out), 8'h12);
        d0_almost_full = 1'b0;
        @(negedge clk);
        check("rel_vc0_pop", 8'(vc0_pop), 8'd1);
        tick();
        check("rel_dout_02", 8'(data_out), 8'h02);

        // Both destinations blocked
        d0_almost_full = 1'b1; d1_almost_full = 1'b1;
        @(negedge clk);
        check("blk_pops", 8'({vc0_pop, vc1_pop}), 8'd0);
        tick();
        check("blk_valid", 8'(valid_out), 8'd0);
        tick();
        d0_almost_full = 1'b0; d1_almost_full = 1'b0;
        vc0_data = 6'h01; vc1_data = 6'h11;
        starve_pattern("blk_cnt0");

        // init during ACTIVE streaming
        tick(); tick();
        init = 1'b1;
        @(negedge clk);
        check("init_pops",  8'({vc0_pop, vc1_pop}), 8'd0);
        check("init_valid", 8'(valid_out), 8'd1);
        check("init_dout",  8'(data_out),  8'h01);
        tick();
        init = 1'b0;
        check("init_st", 8'(state), 8'd1);
        tick();
        starve_pattern("resume");

        // Reset mid-stream: immediate clear, no pops
        reset_L = 1'b0;
        #1;
        check("mrst_state", 8'(state),     8'd0);
        check("mrst_valid", 8'(valid_out), 8'd0);
        check("mrst_data",  8'(data_out),  8'd0);
        check("mrst_pops",  8'({vc0_pop, vc1_pop}), 8'd0);
        tick();
        reset_L = 1'b1;
        tick();
        check("mrst_init", 8'(state), 8'd1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            vc0_empty      = ($urandom_range(0, 3) == 0);
            vc1_empty      = ($urandom_range(0, 3) == 0);
            vc0_data       = 6'($urandom);
            vc1_data       = 6'($urandom);
            d0_almost_full = ($urandom_range(0, 4) == 0);
            d1_almost_full = ($urandom_range(0, 4) == 0);
            init           = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 99) == 0) reset_L = 1'b0;
            else                            reset_L = 1'b1;
            tick();
        end

        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
